// File: rtl/axi4_lite_periph_slave.sv
// AXI4-Lite peripheral slave: LED, seven-segment, IRQ status/enable registers and display scan.
// Optional macro IRQ_SYNC_EN inserts a two-flop synchronizer ahead of the ext_irq_in edge detector.
module axi4_lite_periph_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SCAN_DIV   = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    input  logic                    ext_irq_in,
    output logic [3:0]              leds,
    output logic [6:0]              seg_cathode,
    output logic [3:0]              seg_anode,
    output logic                    irq_out
);
    localparam int SCAN_W = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACC = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACC = 2'd1, R_DATA = 2'd2} r_state_t;

    w_state_t              w_state_q, w_state_d;
    r_state_t              r_state_q, r_state_d;
    logic [3:0]            led_q, led_d;
    logic [16:0]           seg_q, seg_d;
    logic                  irq_status_q, irq_status_d;
    logic                  irq_en_q, irq_en_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  irq_prev_q, irq_prev_d;
    logic                  irq_out_q, irq_out_d;
    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [1:0]            digit_q, digit_d;
    logic [3:0]            anode_q, anode_d;
    logic [6:0]            cathode_q, cathode_d;
    logic                  wr_mapped_s, rd_mapped_s, w1c_s, irq_edge_in_s, irq_rise_s, scan_wrap_s;
    logic [DATA_WIDTH-1:0] rd_val_s;
    logic [3:0]            nibble_s;
    logic                  unused_s;

    // Only the four word offsets in the low nibble are decoded; any other set bit is unmapped.
    function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] a);
        return (a[ADDR_WIDTH-1:4] == {(ADDR_WIDTH-4){1'b0}}) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;  4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;  4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;  4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;  4'hE: s = 7'b0000110;  4'hF: s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

`ifdef IRQ_SYNC_EN
    logic [1:0] irq_sync_q, irq_sync_d;
    // Two-flop synchronizer for the asynchronous interrupt input.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            irq_sync_q <= 2'b00;
        end else begin
            irq_sync_q <= irq_sync_d;
        end
    end
    assign irq_sync_d    = {irq_sync_q[0], ext_irq_in};
    assign irq_edge_in_s = irq_sync_q[1];
`else
    assign irq_edge_in_s = ext_irq_in;
`endif

    // Write FSM, register updates and interrupt status.
    always_comb begin
        w_state_d    = w_state_q;
        led_d        = led_q;
        seg_d        = seg_q;
        irq_en_d     = irq_en_q;
        bresp_d      = bresp_q;
        w1c_s        = 1'b0;
        wr_mapped_s  = addr_mapped(AWADDR);
        case (w_state_q)
            W_IDLE: w_state_d = (AWVALID && WVALID) ? W_ACC : W_IDLE;
            W_ACC: begin
                w_state_d = W_RESP;
                bresp_d   = wr_mapped_s ? 2'b00 : 2'b10;
                if (wr_mapped_s) begin
                    case (AWADDR[3:2])
                        2'd0: led_d = WSTRB[0] ? WDATA[3:0] : led_q;
                        2'd1: seg_d = {WSTRB[2] ? WDATA[16]   : seg_q[16],
                                       WSTRB[1] ? WDATA[15:8] : seg_q[15:8],
                                       WSTRB[0] ? WDATA[7:0]  : seg_q[7:0]};
                        2'd2: w1c_s = WSTRB[0] & WDATA[0];
                        2'd3: irq_en_d = WSTRB[0] ? WDATA[0] : irq_en_q;
                        default: led_d = led_q;
                    endcase
                end else begin
                    led_d = led_q;
                end
            end
            W_RESP: w_state_d = BREADY ? W_IDLE : W_RESP;
            default: w_state_d = W_IDLE;
        endcase
        irq_prev_d   = irq_edge_in_s;
        irq_rise_s   = irq_edge_in_s & ~irq_prev_q;
        // A new edge takes priority over a clear landing in the same cycle.
        irq_status_d = irq_rise_s ? 1'b1 : (w1c_s ? 1'b0 : irq_status_q);
        irq_out_d    = irq_status_q & irq_en_q;
    end

    // Read FSM; RDATA is captured from the pre-update register values.
    always_comb begin
        r_state_d   = r_state_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rd_mapped_s = addr_mapped(ARADDR);
        case (ARADDR[3:2])
            2'd0:    rd_val_s = {{(DATA_WIDTH-4){1'b0}}, led_q};
            2'd1:    rd_val_s = {{(DATA_WIDTH-17){1'b0}}, seg_q};
            2'd2:    rd_val_s = {{(DATA_WIDTH-1){1'b0}}, irq_status_q};
            2'd3:    rd_val_s = {{(DATA_WIDTH-1){1'b0}}, irq_en_q};
            default: rd_val_s = {DATA_WIDTH{1'b0}};
        endcase
        case (r_state_q)
            R_IDLE: r_state_d = ARVALID ? R_ACC : R_IDLE;
            R_ACC: begin
                r_state_d = R_DATA;
                rdata_d   = rd_mapped_s ? rd_val_s : {DATA_WIDTH{1'b0}};
                rresp_d   = rd_mapped_s ? 2'b00 : 2'b10;
            end
            R_DATA:  r_state_d = RREADY ? R_IDLE : R_DATA;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Display scan: digit advances on counter wrap; blanking does not stop the scan.
    always_comb begin
        scan_wrap_s = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d  = scan_wrap_s ? {SCAN_W{1'b0}} : scan_cnt_q + SCAN_W'(1);
        digit_d     = scan_wrap_s ? digit_q + 2'd1 : digit_q;
        case (digit_q)
            2'd0:    nibble_s = seg_q[3:0];
            2'd1:    nibble_s = seg_q[7:4];
            2'd2:    nibble_s = seg_q[11:8];
            2'd3:    nibble_s = seg_q[15:12];
            default: nibble_s = 4'h0;
        endcase
        if (seg_q[16]) begin
            anode_d   = 4'b1111;
            cathode_d = 7'b1111111;
        end else begin
            anode_d   = ~(4'b0001 << digit_q);
            cathode_d = hex_to_seg(nibble_s);
        end
    end

    // State and register flops.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            led_q        <= 4'h0;
            seg_q        <= 17'h0;
            irq_status_q <= 1'b0;
            irq_en_q     <= 1'b0;
            bresp_q      <= 2'b00;
            rresp_q      <= 2'b00;
            rdata_q      <= {DATA_WIDTH{1'b0}};
            irq_prev_q   <= 1'b0;
            irq_out_q    <= 1'b0;
            scan_cnt_q   <= {SCAN_W{1'b0}};
            digit_q      <= 2'd0;
            anode_q      <= 4'b1110;
            cathode_q    <= 7'b1000000;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            led_q        <= led_d;
            seg_q        <= seg_d;
            irq_status_q <= irq_status_d;
            irq_en_q     <= irq_en_d;
            bresp_q      <= bresp_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            irq_prev_q   <= irq_prev_d;
            irq_out_q    <= irq_out_d;
            scan_cnt_q   <= scan_cnt_d;
            digit_q      <= digit_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
        end
    end

    assign AWREADY     = (w_state_q == W_ACC);
    assign WREADY      = (w_state_q == W_ACC);
    assign BVALID      = (w_state_q == W_RESP);
    assign BRESP       = bresp_q;
    assign ARREADY     = (r_state_q == R_ACC);
    assign RVALID      = (r_state_q == R_DATA);
    assign RDATA       = rdata_q;
    assign RRESP       = rresp_q;
    assign leds        = led_q;
    assign seg_anode   = anode_q;
    assign seg_cathode = cathode_q;
    assign irq_out     = irq_out_q;
    assign unused_s    = ^{AWPROT, ARPROT, WDATA[DATA_WIDTH-1:17], WSTRB[DATA_WIDTH/8-1:3]};
endmodule
